// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the pulse handshake transmitter and its receiver-side benches.
package pulse_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK_LOW = 2'd2
    } tx_state_e;

    localparam int PULSE_TX_CNT_W    = 4;
    localparam int PULSE_TX_PEND_MAX = (1 << PULSE_TX_CNT_W) - 1;

    // Largest value the pending counter can hold for a given width.
    function automatic int pend_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/pulse_handshake_tx_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; flops clear to 0 on reset.
module pulse_handshake_tx_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source-domain end of a 4-phase req/ack crossing. Event pulses are queued in a
// pending counter and launched one per handshake. Optional handshake watchdog is
// compiled in with PULSE_TX_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_IDLE    | no handshake in flight; launch when ack_s low and work queued
//   ST_REQ     | req held high, waiting for synchronized ack to rise
//   ST_ACK_LOW | req released, waiting for synchronized ack to fall
module pulse_handshake_tx
    import pulse_tx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_in,
    input  logic             ack,
    output logic             req,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    tx_state_e        state;
    logic             ack_s;
    logic             launch;
    logic [CNT_W-1:0] pending_next;
    logic             overflow_next;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("pulse_handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    pulse_handshake_tx_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack),
        .q     (ack_s)
    );

    assign launch = (state == ST_IDLE) && !ack_s && ((pending != '0) || ev_in);
    assign busy   = (state != ST_IDLE) || (pending != '0);

    // Pending bookkeeping: a launch takes the oldest queued event if there is one,
    // otherwise it consumes the live strobe directly.
    always_comb begin
        pending_next  = pending;
        overflow_next = 1'b0;
        if (launch) begin
            if ((pending != '0) && !ev_in) begin
                pending_next = pending - ONE;
            end
        end else if (ev_in) begin
            if (pending == PEND_MAX) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending + ONE;
            end
        end
    end

    // Register the pending count and the overflow strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

`ifdef PULSE_TX_TIMEOUT_EN
    localparam int              TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    logic [TIMER_W-1:0] timer;

    // Handshake FSM with watchdog; timer reloads on entering each waiting state
    // and fires at terminal count zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            req     <= 1'b0;
            timeout <= 1'b0;
            timer   <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state <= ST_REQ;
                        req   <= 1'b1;
                        timer <= TIMER_LOAD;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        state <= ST_ACK_LOW;
                        req   <= 1'b0;
                        timer <= TIMER_LOAD;
                    end else if (timer == '0) begin
                        state   <= ST_IDLE;
                        req     <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                ST_ACK_LOW: begin
                    if (!ack_s) begin
                        state <= ST_IDLE;
                    end else if (timer == '0) begin
                        state   <= ST_IDLE;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end
`else
    // Handshake FSM; waits on the synchronized ack indefinitely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            req   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state <= ST_REQ;
                        req   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        state <= ST_ACK_LOW;
                        req   <= 1'b0;
                    end
                end
                ST_ACK_LOW: begin
                    if (!ack_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Bench for pulse_handshake_tx: fixed vector table, directed corner sequences and
// randomized traffic against a cycle-level protocol model. Honours PULSE_TX_TIMEOUT_EN.
module tb_pulse_handshake_tx;

    localparam int S    = 2;
    localparam int W    = 4;
    localparam int TO   = 16;
    localparam int PMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ev_in = 1'b0;
    logic         ack = 1'b0;
    logic         req, busy, overflow, timeout;
    logic [W-1:0] pending;

    pulse_handshake_tx #(
        .SYNC_STAGES    (S),
        .CNT_W          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_in    (ev_in),
        .ack      (ack),
        .req      (req),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // protocol model: phase 0 idle, 1 request raised, 2 waiting for ack release
    int m_phase, m_pend;
    bit m_ovf;
    bit ackq[$];

    // receiver behaviour and run statistics
    bit rx_en, rx_rand;
    int rx_rise_dly, rx_fall_dly, rx_wait;
    int rises, ovf_cnt, max_pend;
    bit prev_req;

    typedef struct {
        bit ev;
        bit ak;
        bit exp_req;
        int exp_pend;
        bit exp_busy;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pend  = 0;
        m_ovf   = 1'b0;
        ackq.delete();
    endtask

    task automatic model_edge();
        bit acks;
        bit go;
        acks = (ackq.size() >= S) ? ackq[ackq.size() - S] : 1'b0;
        go = (m_phase == 0) && !acks && (m_pend > 0 || ev_in);
        m_ovf = 1'b0;
        if (go) begin
            if (m_pend > 0) m_pend = m_pend - 1 + int'(ev_in);
        end else if (ev_in) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
        end
        if (m_phase == 0 && go)         m_phase = 1;
        else if (m_phase == 1 && acks)  m_phase = 2;
        else if (m_phase == 2 && !acks) m_phase = 0;
        ackq.push_back(ack);
        if (ackq.size() > S) void'(ackq.pop_front());
    endtask

    task automatic rx_update();
        bit fire;
        if (!rx_en) return;
        if (req !== ack) begin
            rx_wait++;
            if (rx_rand) fire = (rx_wait >= 4) || ($urandom_range(1, 0) == 1);
            else         fire = (rx_wait >= (req ? rx_rise_dly : rx_fall_dly));
            if (fire) begin
                ack = req;
                rx_wait = 0;
            end
        end else begin
            rx_wait = 0;
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 ns later.
    task automatic cyc();
        bit e_req, e_busy;
        @(posedge clk);
        model_edge();
        #1;
        e_req  = (m_phase == 1);
        e_busy = (m_phase != 0) || (m_pend != 0);
        tests++;
        if (req !== e_req || pending !== m_pend[W-1:0] || overflow !== m_ovf ||
            busy !== e_busy || timeout !== 1'b0) begin
            fails++;
            $display("FAIL model t=%0t: req=%b/%b pending=%0d/%0d overflow=%b/%b busy=%b/%b timeout=%b/0 (got/expected)",
                     $time, req, e_req, pending, m_pend, overflow, m_ovf, busy, e_busy, timeout);
        end
        if (req && !prev_req) rises++;
        prev_req = req;
        if (overflow) ovf_cnt++;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        rx_update();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        ev_in = 1'b0;
        while ((busy || req || ack) && n < bound) begin
            cyc();
            n++;
        end
        check("drain_bound", int'(busy || req), 0);
    endtask

    task automatic do_reset(input bit a);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ev_in = 1'b0;
        ack = a;
        rx_en = 1'b0;
        rx_wait = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        prev_req = 1'b0;
    endtask

    initial begin
        int n;
        // table: held inputs for one edge, expected outputs just after it
        tbl[0] = '{1, 0, 1, 0, 1};
        tbl[1] = '{1, 1, 1, 1, 1};
        tbl[2] = '{0, 1, 1, 1, 1};
        tbl[3] = '{0, 1, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 1, 1};
        tbl[6] = '{0, 0, 0, 1, 1};
        tbl[7] = '{1, 0, 1, 1, 1};
        tbl[8] = '{0, 0, 1, 1, 1};

        // reset state
        #3;
        check("rst_req", int'(req), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_timeout", int'(timeout), 0);

        // fixed vectors: latency, ack path through synchronizer, net-zero queue
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            ev_in = tbl[i].ev;
            ack = tbl[i].ak;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i), int'(req), int'(tbl[i].exp_req));
            check($sformatf("vec%0d_pending", i), int'(pending), tbl[i].exp_pend);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
        end

        // single event
        do_reset(1'b0);
        rx_en = 1'b1; rx_rand = 1'b0; rx_rise_dly = 5; rx_fall_dly = 3;
        rises = 0;
        ev_in = 1'b1;
        cyc();
        ev_in = 1'b0;
        check("single_req_latency", int'(req), 1);
        check("single_pending", int'(pending), 0);
        drain(80);
        check("single_handshakes", rises, 1);
        check("single_busy_end", int'(busy), 0);

        // burst of five under a slow receiver
        do_reset(1'b0);
        rx_en = 1'b1; rx_rand = 1'b0; rx_rise_dly = 4; rx_fall_dly = 4;
        rises = 0; ovf_cnt = 0; max_pend = 0;
        ev_in = 1'b1;
        repeat (5) cyc();
        drain(200);
        check("burst_peak_pending", max_pend, 4);
        check("burst_handshakes", rises, 5);
        check("burst_overflow", ovf_cnt, 0);
        check("burst_final_pending", int'(pending), 0);

        // saturation while a stale ack blocks launching
        do_reset(1'b1);
        ovf_cnt = 0; rises = 0;
        repeat (3) cyc();
        ev_in = 1'b1;
        repeat (20) cyc();
        ev_in = 1'b0;
        check("sat_pending", int'(pending), PMAX);
        check("sat_overflow_pulses", ovf_cnt, 20 - PMAX);
        check("sat_req_blocked", int'(req), 0);
        rx_en = 1'b1; rx_rand = 1'b0; rx_rise_dly = 2; rx_fall_dly = 2;
        drain(600);
        check("sat_handshakes", rises, PMAX);

        // stale ack: release, then req rises SYNC_STAGES+1 edges later
        do_reset(1'b1);
        rises = 0;
        repeat (3) cyc();
        ev_in = 1'b1;
        repeat (3) cyc();
        ev_in = 1'b0;
        check("stale_pending", int'(pending), 3);
        check("stale_req", int'(req), 0);
        ack = 1'b0;
        n = 0;
        while (!req && n < 10) begin
            cyc();
            n++;
        end
        check("stale_release_latency", n, S + 1);
        rx_en = 1'b1; rx_rand = 1'b0; rx_rise_dly = 3; rx_fall_dly = 2;
        drain(200);
        check("stale_handshakes", rises, 3);

        // reset in the middle of a request with two queued
        do_reset(1'b0);
        ev_in = 1'b1;
        repeat (3) cyc();
        ev_in = 1'b0;
        check("midrst_req_before", int'(req), 1);
        check("midrst_pending_before", int'(pending), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_async", int'(req), 0);
        check("midrst_pending_async", int'(pending), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        prev_req = 1'b0;
        rises = 0;
        repeat (8) cyc();
        check("midrst_no_relaunch", rises, 0);

        // randomized traffic with a randomly slow receiver
        do_reset(1'b0);
        rx_en = 1'b1; rx_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            ev_in = ($urandom_range(99, 0) < 35);
            cyc();
        end
        drain(400);

        // receiver never acks: watchdog behaviour or indefinite hold
        do_reset(1'b0);
        ev_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ev_in = 1'b0;
        check("wd_pending_queued", int'(pending), 1);
        n = 0;
        repeat (TO - 2) begin
            @(posedge clk); #1;
            if (!req || timeout) n++;
        end
        check("wd_held_before_limit", n, 0);
        @(posedge clk); #1;
`ifdef PULSE_TX_TIMEOUT_EN
        check("wd_timeout_pulse", int'(timeout), 1);
        check("wd_req_dropped", int'(req), 0);
        check("wd_pending_kept", int'(pending), 1);
        @(posedge clk); #1;
        check("wd_timeout_one_cycle", int'(timeout), 0);
        check("wd_relaunch", int'(req), 1);
        check("wd_pending_used", int'(pending), 0);
`else
        check("wd_no_timeout", int'(timeout), 0);
        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!req || timeout) n++;
        end
        check("wd_req_held", n, 0);
        check("wd_pending_kept", int'(pending), 1);
`endif
        do_reset(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
